// File: rtl/user_gpio_in_filter_pkg.sv
// Shared constants and per-channel state types for the GPIO input conditioning stage.
// The counter field is sized for the widest supported filter length; FILT_W must not exceed CNT_MAX_W.
package user_gpio_in_pkg;

    localparam int FILT_W_DFLT = 8;
    localparam int CNT_MAX_W   = 16;

    typedef struct packed {
        logic [1:0]           sync;   // sync[1] is the second (stable) stage
        logic [CNT_MAX_W-1:0] cnt;
        logic                 level;
    } ch_filt_t;

    typedef struct packed {
        logic rise;
        logic fall;
    } ch_flag_t;

endpackage

// File: rtl/user_gpio_in_filter_if.sv
// Bus bundle between the GPIO input register bank (master) and the input filter (slave).
interface user_gpio_in_filter_if
    import user_gpio_in_pkg::*;
#(
    parameter int NR_CH  = 32,
    parameter int FILT_W = FILT_W_DFLT
);
    logic [NR_CH-1:0]  raw_in;
    logic [FILT_W-1:0] filt_len;
    logic [NR_CH-1:0]  flag_clr;
    logic [NR_CH-1:0]  rise_en;
    logic [NR_CH-1:0]  fall_en;
    logic [NR_CH-1:0]  filt_out;
    logic [NR_CH-1:0]  rise_flag;
    logic [NR_CH-1:0]  fall_flag;
    logic              irq;

    modport master (
        output raw_in, filt_len, flag_clr, rise_en, fall_en,
        input  filt_out, rise_flag, fall_flag, irq
    );

    modport slave (
        input  raw_in, filt_len, flag_clr, rise_en, fall_en,
        output filt_out, rise_flag, fall_flag, irq
    );
endinterface

// File: rtl/user_gpio_in_filter_ch.sv
// One input channel: two-flop synchroniser, stability filter and (with
// USER_GPIO_EDGE_CAPTURE_EN) sticky edge flags plus its interrupt term.
module gpio_in_filter_ch
    import user_gpio_in_pkg::*;
#(
    parameter int FILT_W = FILT_W_DFLT
) (
    input  logic              clk,
    input  logic              nReset,
    input  logic              raw_i,
    input  logic [FILT_W-1:0] filt_len_i,
`ifdef USER_GPIO_EDGE_CAPTURE_EN
    input  logic              flag_clr_i,
    input  logic              rise_en_i,
    input  logic              fall_en_i,
    output logic              rise_flag_o,
    output logic              fall_flag_o,
    output logic              irq_term_o,
`endif
    output logic              filt_out_o
);

    ch_filt_t             filt_q, filt_d;
    logic [CNT_MAX_W-1:0] len_ext;

    assign len_ext = CNT_MAX_W'(filt_len_i);

    // >= lets a pending change commit at once when filt_len drops below cnt
    always_comb begin
        filt_d      = filt_q;
        filt_d.sync = {filt_q.sync[0], raw_i};
        if (filt_q.sync[1] == filt_q.level) begin
            filt_d.cnt = '0;
        end else if (filt_q.cnt >= len_ext) begin
            filt_d.level = filt_q.sync[1];
            filt_d.cnt   = '0;
        end else begin
            filt_d.cnt = filt_q.cnt + CNT_MAX_W'(1);
        end
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            filt_q <= '0;
        end else begin
            filt_q <= filt_d;
        end
    end

    assign filt_out_o = filt_q.level;

`ifdef USER_GPIO_EDGE_CAPTURE_EN
    ch_flag_t flag_q, flag_d;

    // Edges come from the next-state level so flags appear with the new filt_out; set beats clear.
    always_comb begin
        flag_d      = flag_q;
        flag_d.rise = (filt_d.level & ~filt_q.level) | (flag_q.rise & ~flag_clr_i);
        flag_d.fall = (~filt_d.level & filt_q.level) | (flag_q.fall & ~flag_clr_i);
    end

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            flag_q <= '0;
        end else begin
            flag_q <= flag_d;
        end
    end

    assign rise_flag_o = flag_q.rise;
    assign fall_flag_o = flag_q.fall;
    assign irq_term_o  = (flag_q.rise & rise_en_i) | (flag_q.fall & fall_en_i);
`endif

endmodule

// File: rtl/user_gpio_in_filter.sv
// GPIO input conditioning: NR_CH filtered channels with optional edge flags and a
// registered irq, both present only when USER_GPIO_EDGE_CAPTURE_EN is defined.
module user_gpio_in_filter
    import user_gpio_in_pkg::*;
#(
    parameter int NR_CH  = 32,
    parameter int FILT_W = FILT_W_DFLT
) (
    input logic                 clk,
    input logic                 nReset,
    user_gpio_in_filter_if.slave bus
);

    logic [NR_CH-1:0] filt_out;
`ifdef USER_GPIO_EDGE_CAPTURE_EN
    logic [NR_CH-1:0] rise_flag;
    logic [NR_CH-1:0] fall_flag;
    logic [NR_CH-1:0] irq_term;
    logic             irq_q, irq_d;
`endif

    for (genvar g = 0; g < NR_CH; g++) begin : g_ch
        gpio_in_filter_ch #(
            .FILT_W (FILT_W)
        ) u_ch (
            .clk         (clk),
            .nReset      (nReset),
            .raw_i       (bus.raw_in[g]),
            .filt_len_i  (bus.filt_len),
`ifdef USER_GPIO_EDGE_CAPTURE_EN
            .flag_clr_i  (bus.flag_clr[g]),
            .rise_en_i   (bus.rise_en[g]),
            .fall_en_i   (bus.fall_en[g]),
            .rise_flag_o (rise_flag[g]),
            .fall_flag_o (fall_flag[g]),
            .irq_term_o  (irq_term[g]),
`endif
            .filt_out_o  (filt_out[g])
        );
    end

    assign bus.filt_out = filt_out;

`ifdef USER_GPIO_EDGE_CAPTURE_EN
    assign irq_d = |irq_term;

    always_ff @(posedge clk or negedge nReset) begin
        if (!nReset) begin
            irq_q <= 1'b0;
        end else begin
            irq_q <= irq_d;
        end
    end

    assign bus.rise_flag = rise_flag;
    assign bus.fall_flag = fall_flag;
    assign bus.irq       = irq_q;
`else
    logic unused_edge_in;

    assign unused_edge_in = ^{bus.flag_clr, bus.rise_en, bus.fall_en};
    assign bus.rise_flag  = '0;
    assign bus.fall_flag  = '0;
    assign bus.irq        = 1'b0;
`endif

endmodule

// File: tb/tb_user_gpio_in_filter.sv
// Directed bench for user_gpio_in_filter; flag/irq expectations follow USER_GPIO_EDGE_CAPTURE_EN.
module tb_user_gpio_in_filter;

`ifdef USER_GPIO_EDGE_CAPTURE_EN
    localparam logic EC = 1'b1;
`else
    localparam logic EC = 1'b0;
`endif

    logic clk;
    logic nReset;
    int   checks;
    int   errors;

    user_gpio_in_filter_if #(.NR_CH(32), .FILT_W(8)) bus ();

    user_gpio_in_filter #(.NR_CH(32), .FILT_W(8)) dut (
        .clk    (clk),
        .nReset (nReset),
        .bus    (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic [31:0] ec_mask(input logic [31:0] v);
        return EC ? v : 32'h0;
    endfunction

    initial begin
        checks        = 0;
        errors        = 0;
        nReset        = 1'b0;
        bus.raw_in    = '0;
        bus.filt_len  = '0;
        bus.flag_clr  = '0;
        bus.rise_en   = '1;
        bus.fall_en   = '1;

        // reset state
        step(3);
        check("rst_filt", bus.filt_out, 32'h0);
        check("rst_rise", bus.rise_flag, 32'h0);
        check("rst_fall", bus.fall_flag, 32'h0);
        check("rst_irq", {31'h0, bus.irq}, 32'h0);
        nReset = 1'b1;
        step(2);

        // filt_len = 0: 3-cycle latency, flag with level, irq one cycle later
        bus.raw_in[0] = 1'b1;
        step(2);
        check("t1_filt_early", bus.filt_out, 32'h0);
        step(1);
        check("t1_filt", bus.filt_out, 32'h1);
        check("t1_rise", bus.rise_flag, ec_mask(32'h1));
        check("t1_irq_early", {31'h0, bus.irq}, 32'h0);
        step(1);
        check("t1_irq", {31'h0, bus.irq}, ec_mask(32'h1));
        bus.flag_clr[0] = 1'b1;
        step(1);
        bus.flag_clr = '0;
        check("t1_rise_clr", bus.rise_flag, 32'h0);
        check("t1_irq_hold", {31'h0, bus.irq}, ec_mask(32'h1));
        step(1);
        check("t1_irq_drop", {31'h0, bus.irq}, 32'h0);
        bus.raw_in[0] = 1'b0;
        step(3);
        check("t1_filt_fall", bus.filt_out, 32'h0);
        check("t1_fall", bus.fall_flag, ec_mask(32'h1));
        step(1);
        check("t1_irq_fall", {31'h0, bus.irq}, ec_mask(32'h1));
        bus.flag_clr = '1;
        step(1);
        bus.flag_clr = '0;
        check("t1_fall_clr", bus.fall_flag, 32'h0);

        // filt_len = 4: 4-cycle pulse rejected
        bus.filt_len  = 8'd4;
        bus.raw_in[1] = 1'b1;
        step(4);
        bus.raw_in[1] = 1'b0;
        for (int i = 0; i < 8; i++) begin
            step(1);
            check("t2_short_filt", bus.filt_out, 32'h0);
        end
        check("t2_short_rise", bus.rise_flag, 32'h0);

        // 5-cycle pulse accepted 7 cycles after the input edge
        bus.raw_in[1] = 1'b1;
        step(5);
        bus.raw_in[1] = 1'b0;
        step(1);
        check("t2_long_e6", bus.filt_out, 32'h0);
        step(1);
        check("t2_long_e7", bus.filt_out, 32'h2);
        check("t2_long_rise", bus.rise_flag, ec_mask(32'h2));
        step(4);
        check("t2_fall_e11", bus.filt_out, 32'h2);
        step(1);
        check("t2_fall_e12", bus.filt_out, 32'h0);
        check("t2_fall_flag", bus.fall_flag, ec_mask(32'h2));

        // filt_len lowered from 10 to 3 while cnt = 6
        bus.filt_len  = 8'd10;
        bus.raw_in[1] = 1'b1;
        step(7);
        check("t3_cnt5", bus.filt_out, 32'h0);
        step(1);
        check("t3_cnt6", bus.filt_out, 32'h0);
        bus.filt_len = 8'd3;
        step(1);
        check("t3_commit", bus.filt_out, 32'h2);
        bus.filt_len = 8'd0;

        // set wins over a simultaneous clear on ch 2
        bus.flag_clr = '1;
        step(1);
        bus.flag_clr = '0;
        step(1);
        check("t4_all_clr_rise", bus.rise_flag, 32'h0);
        check("t4_all_clr_fall", bus.fall_flag, 32'h0);
        check("t4_all_clr_irq", {31'h0, bus.irq}, 32'h0);
        bus.raw_in[2] = 1'b1;
        step(2);
        bus.flag_clr[2] = 1'b1;
        step(1);
        bus.flag_clr = '0;
        check("t4_filt", bus.filt_out, 32'h6);
        check("t4_set_wins", bus.rise_flag, ec_mask(32'h4));
        step(1);
        check("t4_irq", {31'h0, bus.irq}, ec_mask(32'h1));
        bus.flag_clr[2] = 1'b1;
        step(1);
        bus.flag_clr = '0;
        check("t4_clr", bus.rise_flag, 32'h0);
        check("t4_irq_hold", {31'h0, bus.irq}, ec_mask(32'h1));
        step(1);
        check("t4_irq_drop", {31'h0, bus.irq}, 32'h0);

        // reset mid-count on ch 3, then re-acquire every high input
        bus.filt_len  = 8'd4;
        bus.raw_in[3] = 1'b1;
        step(4);
        nReset = 1'b0;
        #1;
        check("t5_rst_filt", bus.filt_out, 32'h0);
        check("t5_rst_rise", bus.rise_flag, 32'h0);
        check("t5_rst_irq", {31'h0, bus.irq}, 32'h0);
        step(2);
        check("t5_rst_hold", bus.filt_out, 32'h0);
        nReset = 1'b1;
        step(6);
        check("t5_pre", bus.filt_out, 32'h0);
        step(1);
        check("t5_filt", bus.filt_out, 32'hE);
        check("t5_rise", bus.rise_flag, ec_mask(32'hE));
        check("t5_fall", bus.fall_flag, 32'h0);
        step(1);
        check("t5_irq", {31'h0, bus.irq}, ec_mask(32'h1));

        // last channel with no filtering
        bus.filt_len   = 8'd0;
        bus.raw_in[31] = 1'b1;
        step(2);
        check("t6_ch31_early", bus.filt_out, 32'hE);
        step(1);
        check("t6_ch31", bus.filt_out, 32'h8000_000E);
        check("t6_ch31_rise", bus.rise_flag, ec_mask(32'h8000_000E));

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
